mfp_loader_ahb_write_buffer: RTL and testbench

//  Sits between the serial SREC parser and the AHB-Lite loader mux.
//  - Coalesces the parser's single-byte writes into word-aligned entries.
//  - Buffers them in a small FIFO.
//  - Issues them as AHB-Lite single writes: one word write when all 4 lanes are present, byte writes otherwise.
//  - Honours HREADY wait states, so slow slaves (SRAM) never lose loader data.

---
 rtl/mfp_loader_ahb_write_buffer_if.sv | 14 +
 rtl/mfp_loader_ahb_write_buffer.sv | 126 ++++++++++++
 tb/tb_mfp_loader_ahb_write_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_loader_ahb_write_buffer_if.sv
// mfp_loader_ahb_write_buffer_if: AHB-Lite write-only master bus between the loader buffer and the loader mux.
interface mfp_loader_ahb_write_buffer_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    modport master (output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE, input HREADY);
    modport slave (input HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE, output HREADY);
endinterface

// File: rtl/mfp_loader_ahb_write_buffer.sv
// mfp_loader_ahb_write_buffer: coalesces SREC parser byte writes into words, buffers them and
// issues them as AHB-Lite single writes (word when all lanes present, byte writes otherwise).
module mfp_loader_ahb_write_buffer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        big_endian,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    input  logic        flush,
    mfp_loader_ahb_write_buffer_if.master ahb,
    output logic        busy,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    logic [29:0] acc_addr, x_addr, n_addr;
    logic [31:0] acc_data, x_data, n_data, lane_bits, byte_bits, byte_data;
    logic [3:0]  acc_mask, rem, n_mask;
    logic [1:0]  in_lane, x_off, n_off, out_lane;
    logic        flush_pend, acc_full, new_word, push, pop, fifo_ne, fifo_full, x_word, n_word;
    logic [AW:0] wp, rp;
    entry_t      mem [FIFO_DEPTH];
    entry_t      head;

    assign ahb.HBURST    = 3'b000;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = 4'b0011;

    // Mask bits are indexed by byte offset; data is held in bus lane layout.
    always_comb begin
        in_lane   = big_endian ? ~write_address[1:0] : write_address[1:0];
        lane_bits = 32'hFF << {in_lane, 3'b000};
        byte_bits = {24'h0, write_byte} << {in_lane, 3'b000};
        acc_full  = acc_mask == 4'hF;
        new_word  = acc_mask == 4'h0 || acc_full || write_address[31:2] != acc_addr;
        push      = acc_full
                  || (write_enable && acc_mask != 4'h0 && write_address[31:2] != acc_addr)
                  || (flush_pend && !write_enable && acc_mask != 4'h0);
        fifo_ne   = wp != rp;
        fifo_full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
        head      = mem[rp[AW-1:0]];
        pop       = fifo_ne && (state == IDLE || (state == DATA && ahb.HREADY && rem == 4'h0));
        n_addr    = pop ? head.addr : x_addr;
        n_data    = pop ? head.data : x_data;
        n_mask    = pop ? head.mask : rem;
        n_word    = n_mask == 4'hF;
        n_off     = n_mask[0] ? 2'd0 : n_mask[1] ? 2'd1 : n_mask[2] ? 2'd2 : 2'd3;
        out_lane  = big_endian ? ~x_off : x_off;
        byte_data = x_data & (32'hFF << {out_lane, 3'b000});
        busy      = acc_mask != 4'h0 || flush_pend || fifo_ne || state != IDLE;
    end

    always_ff @(posedge HCLK)
        if (push && (!fifo_full || pop))
            mem[wp[AW-1:0]] <= {acc_addr, acc_data, acc_mask};

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            acc_addr   <= '0;
            acc_data   <= '0;
            acc_mask   <= '0;
            flush_pend <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            overflow   <= 1'b0;
        end else begin
            if (write_enable) begin
                acc_addr <= write_address[31:2];
                acc_data <= (new_word ? 32'h0 : acc_data & ~lane_bits) | byte_bits;
                acc_mask <= (new_word ? 4'h0 : acc_mask) | (4'b0001 << write_address[1:0]);
            end else if (push) begin
                acc_mask <= 4'h0;
            end
            flush_pend <= flush ? (acc_mask != 4'h0 || write_enable) : flush_pend && (write_enable || acc_full);
            if (push && (!fifo_full || pop))
                wp <= wp + 1'b1;
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end

    // No address pipelining: every transfer walks ADDR then DATA before the next address phase.
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state      <= IDLE;
            ahb.HADDR  <= '0;
            ahb.HSIZE  <= '0;
            ahb.HTRANS <= 2'b00;
            ahb.HWRITE <= 1'b0;
            ahb.HWDATA <= '0;
            x_addr     <= '0;
            x_data     <= '0;
            x_word     <= 1'b0;
            x_off      <= '0;
            rem        <= '0;
        end else if (pop || (state == DATA && ahb.HREADY && rem != 4'h0)) begin
            state      <= ADDR;
            ahb.HADDR  <= {n_addr, n_word ? 2'b00 : n_off};
            ahb.HSIZE  <= n_word ? 3'b010 : 3'b000;
            ahb.HTRANS <= 2'b10;
            ahb.HWRITE <= 1'b1;
            x_addr     <= n_addr;
            x_data     <= n_data;
            x_word     <= n_word;
            x_off      <= n_off;
            rem        <= n_word ? 4'h0 : n_mask & ~(4'b0001 << n_off);
        end else if (state == ADDR && ahb.HREADY) begin
            state      <= DATA;
            ahb.HTRANS <= 2'b00;
            ahb.HWRITE <= 1'b0;
            ahb.HWDATA <= x_word ? x_data : byte_data;
        end else if (state == DATA && ahb.HREADY) begin
            state <= IDLE;
        end
endmodule

// File: tb/tb_mfp_loader_ahb_write_buffer.sv
// tb_mfp_loader_ahb_write_buffer: directed self-checking bench; a bus monitor records every
// completed address and data phase for comparison against hand-computed values.
module tb_mfp_loader_ahb_write_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        big_endian, we, flush;
    logic [31:0] wa;
    logic [7:0]  wb;
    logic        busy, overflow;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] aq[$];
    logic [31:0] dq[$];
    logic [2:0]  sq[$];
    logic        dp;

    mfp_loader_ahb_write_buffer_if bus ();

    mfp_loader_ahb_write_buffer #(.FIFO_DEPTH(4)) dut (
        .HCLK(clk),
        .HRESETn(rst_n),
        .big_endian(big_endian),
        .write_address(wa),
        .write_byte(wb),
        .write_enable(we),
        .flush(flush),
        .ahb(bus),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dp <= 1'b0;
        end else if (bus.HREADY) begin
            if (dp)
                dq.push_back(bus.HWDATA);
            if (bus.HTRANS == 2'b10) begin
                aq.push_back(bus.HADDR);
                sq.push_back(bus.HSIZE);
            end
            dp <= bus.HTRANS == 2'b10;
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] b);
        @(negedge clk);
        we = 1'b1;
        flush = 1'b0;
        wa = a;
        wb = b;
    endtask

    task automatic fl();
        @(negedge clk);
        we = 1'b0;
        flush = 1'b1;
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        we = 1'b0;
        flush = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        settle(0);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    task automatic wait_addr(input string tag);
        int k = 0;
        settle(0);
        while (bus.HTRANS != 2'b10 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(bus.HTRANS), 32'h2);
    endtask

    task automatic clr();
        aq.delete();
        dq.delete();
        sq.delete();
    endtask

    function automatic logic [31:0] qa(input int i);
        return aq.size() > i ? aq[i] : 'x;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return dq.size() > i ? dq[i] : 'x;
    endfunction

    function automatic logic [31:0] qs(input int i);
        return sq.size() > i ? 32'(sq[i]) : 'x;
    endfunction

    initial begin
        rst_n = 1'b0;
        big_endian = 1'b0;
        we = 1'b0;
        flush = 1'b0;
        wa = '0;
        wb = '0;
        bus.HREADY = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_htrans", 32'(bus.HTRANS), 32'h0);
        check("rst_haddr", bus.HADDR, 32'h0);
        check("rst_hwrite", 32'(bus.HWRITE), 32'h0);
        check("rst_hwdata", bus.HWDATA, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("const_hburst", 32'(bus.HBURST), 32'h0);
        check("const_hprot", 32'(bus.HPROT), 32'h3);
        check("const_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
        rst_n = 1'b1;

        wr(32'h100, 8'h11); wr(32'h101, 8'h22); wr(32'h102, 8'h33); wr(32'h103, 8'h44);
        wait_idle("t1_idle");
        check("t1_count", aq.size(), 32'd1);
        check("t1_haddr", qa(0), 32'h100);
        check("t1_hsize", qs(0), 32'h2);
        check("t1_hwdata", qd(0), 32'h44332211);

        clr();
        @(negedge clk) big_endian = 1'b1;
        wr(32'h100, 8'h11); wr(32'h101, 8'h22); wr(32'h102, 8'h33); wr(32'h103, 8'h44);
        wait_idle("t2_idle");
        check("t2_count", aq.size(), 32'd1);
        check("t2_haddr", qa(0), 32'h100);
        check("t2_hwdata", qd(0), 32'h11223344);
        big_endian = 1'b0;

        clr();
        wr(32'h205, 8'hAA);
        fl();
        wait_idle("t3a_idle");
        check("t3a_count", aq.size(), 32'd1);
        check("t3a_haddr", qa(0), 32'h205);
        check("t3a_hsize", qs(0), 32'h0);
        check("t3a_hwdata", qd(0), 32'h0000AA00);
        clr();
        wr(32'h301, 8'h55); wr(32'h303, 8'h66);
        fl();
        wait_idle("t3b_idle");
        check("t3b_count", aq.size(), 32'd2);
        check("t3b_haddr0", qa(0), 32'h301);
        check("t3b_haddr1", qa(1), 32'h303);
        check("t3b_hsize1", qs(1), 32'h0);
        check("t3b_hwdata0", qd(0), 32'h00005500);
        check("t3b_hwdata1", qd(1), 32'h66000000);

        clr();
        @(negedge clk) bus.HREADY = 1'b0;
        wr(32'h500, 8'hA1); wr(32'h501, 8'hA2); wr(32'h502, 8'hA3); wr(32'h503, 8'hA4);
        wait_addr("t4_addr_phase");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_haddr_held", bus.HADDR, 32'h500);
            check("t4_htrans_held", 32'(bus.HTRANS), 32'h2);
        end
        bus.HREADY = 1'b1;
        @(negedge clk) bus.HREADY = 1'b0;
        check("t4_data_htrans", 32'(bus.HTRANS), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hwdata_held", bus.HWDATA, 32'hA4A3A2A1);
        end
        bus.HREADY = 1'b1;
        wait_idle("t4_idle");
        check("t4_addr_count", aq.size(), 32'd1);
        check("t4_data_count", dq.size(), 32'd1);
        check("t4_hwdata", qd(0), 32'hA4A3A2A1);

        clr();
        @(negedge clk) bus.HREADY = 1'b0;
        for (int i = 1; i <= 6; i++)
            for (int j = 0; j < 4; j++)
                wr(32'h600 + 32'(16 * (i - 1) + j), 8'(i));
        settle(6);
        check("t5_overflow", 32'(overflow), 32'h1);
        bus.HREADY = 1'b1;
        wait_idle("t5_idle");
        check("t5_count", aq.size(), 32'd5);
        check("t5_haddr_first", qa(0), 32'h600);
        check("t5_haddr_last", qa(4), 32'h640);
        check("t5_hwdata_last", qd(4), 32'h05050505);
        check("t5_overflow_sticky", 32'(overflow), 32'h1);

        clr();
        @(negedge clk) bus.HREADY = 1'b0;
        wr(32'h700, 8'h07); wr(32'h701, 8'h07); wr(32'h702, 8'h07); wr(32'h703, 8'h07);
        wait_addr("t6_addr_phase");
        bus.HREADY = 1'b1;
        @(negedge clk) bus.HREADY = 1'b0;
        check("t6_in_data", bus.HWDATA, 32'h07070707);
        #2 rst_n = 1'b0;
        #1;
        check("t6_htrans", 32'(bus.HTRANS), 32'h0);
        check("t6_hwdata", bus.HWDATA, 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.HREADY = 1'b1;
        clr();
        repeat (10) @(negedge clk);
        check("t6_no_transfer", aq.size(), 32'd0);
        check("t6_busy_after", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
